fifo_wr_packer: RTL

Write-domain width-packing stage that sits directly upstream of the async FIFO. It accepts a narrow valid/ready bead stream, packs RATIO = DATA_WIDTH/IN_WIDTH beads per FIFO word (LSB-first), and zero-pads a short final word on `s_last`. It drives the FIFO write port and honours `w_full`. It adds one holding register and a one-word park slot, so no combinational path runs from FIFO full to `s_ready`.

---
 rtl/fifo_wr_pkg.sv | 17 +
 rtl/fifo_wr_packer_wrap_counter.sv | 33 +++
 rtl/fifo_wr_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_wr_pkg.sv
// Shared constants and helpers for the FIFO write-side bead packer.
package fifo_wr_pkg;

    // Default width of the status counters.
    localparam int CNT_W_DEF = 16;

    // Number of input beads that fill one FIFO word.
    function automatic int calc_ratio(input int data_w, input int in_w);
        return (in_w > 0) ? (data_w / in_w) : 0;
    endfunction

    // Width of the bead-index counter, $clog2(RATIO), never below one bit.
    function automatic int bead_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_packer_wrap_counter.sv
// Free-running event counter that wraps at 2**W; used for write statistics.
module fifo_wr_packer_wrap_counter #(
    parameter int W = 16
) (
    input  logic         w_clk,
    input  logic         w_rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one on each qualifying event.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs a narrow bead stream LSB-first into FIFO words, zero-padding short
// words on s_last. A holding register plus a one-word park slot in the
// accumulator keep s_ready purely registered (no path from f_w_full).
module fifo_wr_packer
    import fifo_wr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_WIDTH   = 2,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic                  s_last,
    output logic                  f_w_en,
    output logic [DATA_WIDTH-1:0] f_w_data,
    input  logic                  f_w_full,
    output logic [CNT_W-1:0]      words_written,
    output logic [CNT_W-1:0]      padded_words
);

    localparam int RATIO = calc_ratio(DATA_WIDTH, IN_WIDTH);
    localparam int IDX_W = bead_idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((DATA_WIDTH % IN_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_wr_packer: DATA_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
    end

    logic [DATA_WIDTH-1:0] acc_q,       acc_d;
    logic                  acc_pad_q,   acc_pad_d;
    logic [IDX_W-1:0]      cnt_q,       cnt_d;
    logic                  pend_q,      pend_d;
    logic [DATA_WIDTH-1:0] out_reg_q,   out_reg_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_pad_q,   out_pad_d;

    logic                  accept;
    logic                  close;
    logic                  out_free;
    logic                  pad_new;
    logic [DATA_WIDTH-1:0] acc_ins;

    assign s_ready  = !pend_q;
    assign accept   = s_valid && !pend_q;
    assign f_w_en   = out_valid_q && !f_w_full;
    assign f_w_data = out_reg_q;
    assign out_free = !out_valid_q || f_w_en;
    assign close    = accept && (s_last || (cnt_q == LAST_IDX));
    assign pad_new  = s_last && (cnt_q != LAST_IDX);

    // Accumulator with the incoming bead dropped into its lane; lanes above
    // cnt are already zero because acc is cleared whenever a word leaves it.
    always_comb begin
        acc_ins = acc_q;
        acc_ins[cnt_q*IN_WIDTH +: IN_WIDTH] = s_data;
    end

    // Next-state: bead packing, word routing into out_reg or the park slot.
    always_comb begin
        acc_d       = acc_q;
        acc_pad_d   = acc_pad_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        out_reg_d   = out_reg_q;
        out_pad_d   = out_pad_q;
        out_valid_d = out_valid_q && !f_w_en;

        if (pend_q) begin
            // Parked word drains as soon as the holding register frees up.
            if (out_free) begin
                out_reg_d   = acc_q;
                out_pad_d   = acc_pad_q;
                out_valid_d = 1'b1;
                pend_d      = 1'b0;
                acc_d       = '0;
                acc_pad_d   = 1'b0;
            end
        end else if (close) begin
            cnt_d = '0;
            if (out_free) begin
                out_reg_d   = acc_ins;
                out_pad_d   = pad_new;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_pad_d   = 1'b0;
            end else begin
                acc_d     = acc_ins;
                acc_pad_d = pad_new;
                pend_d    = 1'b1;
            end
        end else if (accept) begin
            acc_d = acc_ins;
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // State registers; reset discards partial, parked and held words.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            acc_q       <= '0;
            acc_pad_q   <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
            out_pad_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_pad_q   <= acc_pad_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
            out_pad_q   <= out_pad_d;
        end
    end

    fifo_wr_packer_wrap_counter #(.W(CNT_W)) u_words_cnt (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .inc     (f_w_en),
        .count   (words_written)
    );

    fifo_wr_packer_wrap_counter #(.W(CNT_W)) u_pad_cnt (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .inc     (f_w_en && out_pad_q),
        .count   (padded_words)
    );

endmodule
